split_check_sequencer: RTL and testbench

//   Rejection-sampling controller for the split constraint checkers. Requests a candidate

---
 rtl/split_check_sequencer.sv | 130 +++++++++++++
 tb/tb_split_check_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_check_sequencer.sv
// split_check_sequencer
// Rejection-sampling controller: fetches a candidate assignment from the stimulus
// generator, then walks the split checkers one per cycle through split_sel and
// samples the muxed pass bit. A candidate is accepted only when every split passes.
// The first failing split discards the candidate and a new one is requested, up to
// MAX_TRIES candidates per solve.
//
// Handshake: cand_req acts as "ready" and cand_valid as "valid". A candidate moves
// across in the cycle where both are high (cand_load). cand_req stays high for the
// whole REQ state and does not depend on cand_valid. The generator may hold
// cand_valid high, or assert it late, without any timeout.
//
// state_dbg exposes the FSM encoding (0=IDLE 1=REQ 2=CHECK 3=DONE) for checkers.
module split_check_sequencer #(
  parameter int NUM_SPLITS = 4,
  parameter int MAX_TRIES  = 16,
  localparam int SEL_W = (NUM_SPLITS > 1) ? $clog2(NUM_SPLITS) : 1,
  localparam int TRY_W = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             cand_req,
  input  logic             cand_valid,
  output logic             cand_load,
  output logic [SEL_W-1:0] split_sel,
  input  logic             split_pass,
  output logic             busy,
  output logic             done,
  output logic             accepted,
  output logic [TRY_W-1:0] tries_used,
  output logic [SEL_W-1:0] fail_idx,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_split;
  logic tries_max;
  logic abort_now;
  logic start_now;

  assign last_split = (split_sel == SEL_W'(NUM_SPLITS - 1));
  assign tries_max  = (tries_used == TRY_W'(MAX_TRIES));
  // abort only matters outside IDLE; in IDLE start is the sole trigger
  assign abort_now  = abort && (state != S_IDLE);
  assign start_now  = start && (state == S_IDLE);

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition out of a busy state
  always_comb begin
    state_nxt = state;
    if (abort_now) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_REQ;
        S_REQ:   if (cand_valid) state_nxt = S_CHECK;
        S_CHECK: begin
          if (split_pass) begin
            if (last_split) state_nxt = S_DONE;
          end else begin
            state_nxt = tries_max ? S_DONE : S_REQ;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded directly from the current state
  always_comb begin
    cand_req  = (state == S_REQ);
    cand_load = (state == S_REQ) && cand_valid;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    state_dbg = state;
  end

  // Solve bookkeeping: split index, try counter, verdict and last rejecting split
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_sel  <= '0;
      tries_used <= '0;
      accepted   <= 1'b0;
      fail_idx   <= '0;
    end else if (abort_now) begin
      // tries_used deliberately holds so software can see how far the solve got
      accepted <= 1'b0;
    end else if (start_now) begin
      split_sel  <= '0;
      tries_used <= '0;
      accepted   <= 1'b0;
    end else if (state == S_REQ) begin
      if (cand_valid) begin
        tries_used <= tries_used + 1'b1;
        split_sel  <= '0;
      end
    end else if (state == S_CHECK) begin
      if (split_pass) begin
        if (last_split) begin
          accepted <= 1'b1;
        end else begin
          split_sel <= split_sel + 1'b1;
        end
      end else begin
        fail_idx <= split_sel;
      end
    end
  end

endmodule

// File: tb/tb_split_check_sequencer.sv
// Directed bench for split_check_sequencer (NUM_SPLITS=4, MAX_TRIES=16).
module tb_split_check_sequencer;

  localparam int NUM_SPLITS = 4;
  localparam int MAX_TRIES  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       start      = 1'b0;
  logic       abort      = 1'b0;
  logic       cand_valid = 1'b1;
  logic       cand_req;
  logic       cand_load;
  logic [1:0] split_sel;
  logic       split_pass;
  logic       busy;
  logic       done;
  logic       accepted;
  logic [4:0] tries_used;
  logic [1:0] fail_idx;
  logic [1:0] state_dbg;

  split_check_sequencer #(
    .NUM_SPLITS(NUM_SPLITS),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cand_req  (cand_req),
    .cand_valid(cand_valid),
    .cand_load (cand_load),
    .split_sel (split_sel),
    .split_pass(split_pass),
    .busy      (busy),
    .done      (done),
    .accepted  (accepted),
    .tries_used(tries_used),
    .fail_idx  (fail_idx),
    .state_dbg (state_dbg)
  );

  // ---------------- checker model ----------------
  // mode 0: every split passes; mode 1: split 2 fails for the first 3 candidates;
  // mode 2: every split fails.
  logic [1:0] mode      = 2'd0;
  logic       loads_clr = 1'b0;
  int         loads     = 0;
  int         sel3_bad  = 0;

  assign split_pass = (mode == 2'd0) ? 1'b1 :
                      (mode == 2'd1) ? !((split_sel == 2'd2) && (loads <= 3)) :
                      1'b0;

  // count candidate transfers and visits to split 3 on candidates that must be rejected
  always @(posedge clk) begin
    if (loads_clr) begin
      loads    <= 0;
      sel3_bad <= 0;
    end else begin
      if (cand_load) loads <= loads + 1;
      if (mode == 2'd1 && state_dbg == 2'd2 && split_sel == 2'd3 && loads <= 3)
        sel3_bad <= sel3_bad + 1;
    end
  end

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;
  logic got_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_loads();
    loads_clr = 1'b1;
    tick();
    loads_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    got_done = 1'b0;
    for (int i = 0; i < max_cyc && !got_done; i++) begin
      tick();
      if (done) got_done = 1'b1;
    end
    check(tag, {31'd0, got_done}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy",     busy, 0);
    check("rst_done",     done, 0);
    check("rst_cand_req", cand_req, 0);
    check("rst_load",     cand_load, 0);
    check("rst_accepted", accepted, 0);
    check("rst_sel",      split_sel, 0);
    check("rst_tries",    tries_used, 0);
    check("rst_fail_idx", fail_idx, 0);

    // 1: all pass, candidate always valid -> done exactly 6 cycles after start
    mode = 2'd0; cand_valid = 1'b1;
    clear_loads();
    pulse_start();                       // now in REQ (T+1)
    check("t1_req",      cand_req, 1);
    check("t1_busy",     busy, 1);
    check("t1_load",     cand_load, 1);
    for (int i = 0; i < NUM_SPLITS; i++) begin
      tick();                            // CHECK at T+2..T+5
      check("t1_state_check", state_dbg, 2);
      check("t1_sel",    split_sel, i);
      check("t1_nodone", done, 0);
    end
    tick();                              // T+6
    check("t1_done",     done, 1);
    check("t1_accepted", accepted, 1);
    check("t1_tries",    tries_used, 1);
    tick();
    check("t1_done_gone", done, 0);
    check("t1_idle",     busy, 0);
    check("t1_acc_hold", accepted, 1);

    // 2: split 2 rejects the first 3 candidates, 4th passes
    mode = 2'd1;
    clear_loads();
    pulse_start();
    wait_done("t2_done_seen", 100);
    check("t2_accepted", accepted, 1);
    check("t2_tries",    tries_used, 4);
    check("t2_fail_idx", fail_idx, 2);
    check("t2_loads",    loads, 4);
    check("t2_no_sel3",  sel3_bad, 0);
    tick();

    // 3: everything fails -> gives up after MAX_TRIES candidates
    mode = 2'd2;
    clear_loads();
    pulse_start();
    wait_done("t3_done_seen", 200);
    check("t3_accepted", accepted, 0);
    check("t3_tries",    tries_used, MAX_TRIES);
    check("t3_fail_idx", fail_idx, 0);
    tick();
    check("t3_loads",    loads, MAX_TRIES);
    check("t3_idle",     busy, 0);
    check("t3_tries_hold", tries_used, MAX_TRIES);

    // 4: generator stalls for 10 cycles in REQ
    mode = 2'd0; cand_valid = 1'b0;
    clear_loads();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      check("t4_req_hold",   cand_req, 1);
      check("t4_state_req",  state_dbg, 1);
      check("t4_no_load",    cand_load, 0);
      tick();
    end
    check("t4_tries_wait", tries_used, 0);
    cand_valid = 1'b1;
    #1;
    check("t4_load_now", cand_load, 1);
    tick();
    check("t4_state_check", state_dbg, 2);
    check("t4_tries",    tries_used, 1);
    wait_done("t4_done_seen", 20);
    check("t4_accepted", accepted, 1);
    tick();

    // 5: abort while checking the 2nd candidate
    mode = 2'd1;
    clear_loads();
    pulse_start();
    for (int i = 0; i < 20 && !(loads == 2 && state_dbg == 2'd2); i++) tick();
    check("t5_reached_cand2", {31'd0, (loads == 2 && state_dbg == 2'd2)}, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle",     busy, 0);
    check("t5_state",    state_dbg, 0);
    check("t5_no_done",  done, 0);
    check("t5_tries",    tries_used, 2);
    check("t5_accepted", accepted, 0);
    got_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) got_done = 1'b1;
    end
    check("t5_no_late_done", {31'd0, got_done}, 0);
    abort = 1'b1;                        // abort in IDLE has no effect
    tick();
    abort = 1'b0;
    check("t5_idle_abort", tries_used, 2);
    mode = 2'd0;
    pulse_start();
    wait_done("t5_restart_done", 20);
    check("t5_restart_acc",   accepted, 1);
    check("t5_restart_tries", tries_used, 1);
    tick();

    // 6: start while busy is ignored, then asynchronous reset mid-CHECK
    mode = 2'd2;
    pulse_start();                       // REQ
    tick();                              // CHECK, tries 1
    start = 1'b1;
    tick();                              // REQ
    tick();                              // CHECK, tries 2
    start = 1'b0;
    check("t6_start_ignored", tries_used, 2);
    check("t6_state_check",   state_dbg, 2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_busy",     busy, 0);
    check("t6_rst_req",      cand_req, 0);
    check("t6_rst_done",     done, 0);
    check("t6_rst_tries",    tries_used, 0);
    check("t6_rst_sel",      split_sel, 0);
    check("t6_rst_accepted", accepted, 0);
    check("t6_rst_fail_idx", fail_idx, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_post_idle", busy, 0);
    check("t6_post_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
